// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port-B arbiter: state encoding and defaults.
package dmem_port_arbiter_pkg;

    typedef enum logic {
        ARB_RUN    = 1'b0,
        ARB_HALTED = 1'b1
    } arb_state_t;

    localparam int         DEFAULT_MAX_WAIT = 4;
    localparam logic [7:0] WAIT_SAT         = 8'hFF;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates BRAM port B between the core EX-stage load/store path and a host requester,
// with core priority, a host starvation guard and a halt mode giving the host exclusive access.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT  = DEFAULT_MAX_WAIT,
    parameter bit BOOT_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [3:0]  core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [3:0]  host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    input  logic        host_halt_req,
    output logic        host_halted,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_di,
    input  logic [31:0] bram_do
);

    localparam arb_state_t RESET_STATE = BOOT_HALT ? ARB_HALTED : ARB_RUN;
    localparam logic [7:0] MAX_WAIT_L  = 8'(MAX_WAIT);

    arb_state_t  state_reg;
    logic [7:0]  wait_cnt_reg;
    logic        rd_pend_reg;

    logic        force_grant;
    logic        host_gnt;
    logic        core_served;

    assign force_grant = (wait_cnt_reg >= MAX_WAIT_L);

    always_comb begin
        host_gnt   = 1'b0;
        core_stall = 1'b0;
        if (state_reg == ARB_HALTED) begin
            host_gnt   = host_valid;
            core_stall = 1'b1;
        end else begin
            host_gnt   = host_valid & (~core_req | force_grant);
            core_stall = core_req & host_gnt;
        end
    end

    assign core_served = core_req & ~core_stall;
    assign host_ready  = host_gnt;

    // Idle cycles still present the core address with writes masked off: a harmless read.
    always_comb begin
        bram_we   = 4'h0;
        bram_addr = core_addr;
        bram_di   = core_wdata;
        if (host_gnt) begin
            bram_we   = host_we;
            bram_addr = host_addr;
            bram_di   = host_wdata;
        end else if (core_served) begin
            bram_we   = core_we;
        end
    end

    assign host_rvalid = rd_pend_reg;
    assign host_rdata  = rd_pend_reg ? bram_do : 32'h0;
    assign host_halted = (state_reg == ARB_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RESET_STATE;
            wait_cnt_reg <= 8'h00;
            rd_pend_reg  <= 1'b0;
        end else begin
            state_reg   <= host_halt_req ? ARB_HALTED : ARB_RUN;
            rd_pend_reg <= host_gnt & (host_we == 4'h0);
            // Count only cycles the host actually lost to the core while running.
            if ((state_reg == ARB_RUN) && host_valid && !host_gnt) begin
                wait_cnt_reg <= (wait_cnt_reg == WAIT_SAT) ? WAIT_SAT : wait_cnt_reg + 8'h01;
            end else begin
                wait_cnt_reg <= 8'h00;
            end
        end
    end

endmodule
